gwa_input_cond: RTL and testbench

Front-end conditioner for the drinks-vending FSM. It takes raw, asynchronous, bouncing signals from the 1-euro coin slot, the 2-euro coin slot and the select button, and turns each press or insertion into exactly one single-cycle pulse. Output pulses are mutually exclusive, so the downstream Mealy FSM never sees two events in the same cycle. Events that qualify together are buffered and released one per cycle in fixed priority.

---
 rtl/gwa_pkg.sv | 30 +++
 rtl/gwa_debounce.sv | 47 ++++
 rtl/gwa_input_cond.sv | 75 +++++++
 tb/tb_gwa_input_cond.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/gwa_pkg.sv
// Shared constants for the vending-machine input conditioner: channel indices,
// default debounce length and the fixed issue priority.
package gwa_pkg;

  localparam int NCH    = 3;
  localparam int CH_EU1 = 0;
  localparam int CH_EU2 = 1;
  localparam int CH_WT  = 2;

  localparam int DEB_CYCLES_DEF = 4;

  // Issue order, highest priority first.
  localparam int PRIO [NCH] = '{CH_EU1, CH_EU2, CH_WT};

  typedef logic [NCH-1:0] ch_vec_t;

  // One-hot grant of the highest-priority requesting channel, or zero.
  function automatic ch_vec_t pick_first(input ch_vec_t req);
    ch_vec_t g;
    g = '0;
    for (int p = NCH - 1; p >= 0; p--) begin
      if (req[PRIO[p]]) begin
        g = '0;
        g[PRIO[p]] = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/gwa_debounce.sv
// Single-channel front end: two-flop synchroniser, debounce counter and a
// combinational strobe that is high at the edge where the debounced level rises.
module gwa_debounce
  import gwa_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             s1_reg;
  logic             s2_reg;
  logic             deb_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             settle;

  // s2 has disagreed with the debounced level for DEB_CYCLES edges in a row.
  assign settle = (s2_reg != deb_reg) && (cnt_reg == CNT_MAX);
  assign rise   = settle & s2_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_reg  <= 1'b0;
      s2_reg  <= 1'b0;
      deb_reg <= 1'b0;
      cnt_reg <= '0;
    end else begin
      s1_reg <= raw;
      s2_reg <= s1_reg;
      if (s2_reg == deb_reg) begin
        cnt_reg <= '0;
      end else if (settle) begin
        deb_reg <= s2_reg;
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gwa_input_cond.sv
// Turns bouncing coin/select inputs into mutually exclusive single-cycle pulses,
// buffering coincident events and releasing them one per cycle by priority.
module gwa_input_cond
  import gwa_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic eu1_raw,
  input  logic eu2_raw,
  input  logic wt_raw,
  input  logic hold,
  output logic eu1,
  output logic eu2,
  output logic wt,
  output logic ovf
);

  ch_vec_t raw_vec;
  ch_vec_t rise_vec;
  ch_vec_t grant;
  ch_vec_t pending_reg;
  ch_vec_t pending_next;
  ch_vec_t out_reg;
  logic    ovf_reg;
  logic    ovf_next;

  assign raw_vec[CH_EU1] = eu1_raw;
  assign raw_vec[CH_EU2] = eu2_raw;
  assign raw_vec[CH_WT]  = wt_raw;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      gwa_debounce #(
        .DEB_CYCLES(DEB_CYCLES),
        .CNT_W     (CNT_W)
      ) u_deb (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (raw_vec[gi]),
        .rise (rise_vec[gi])
      );
    end
  endgenerate

  // A rise on a channel that stays pending is lost; one being issued now re-arms.
  always_comb begin
    grant = '0;
    if (!hold) begin
      grant = pick_first(pending_reg);
    end
    pending_next = (pending_reg & ~grant) | rise_vec;
    ovf_next     = |(rise_vec & pending_reg & ~grant);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_reg <= '0;
      out_reg     <= '0;
      ovf_reg     <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      out_reg     <= grant;
      ovf_reg     <= ovf_next;
    end
  end

  assign eu1 = out_reg[CH_EU1];
  assign eu2 = out_reg[CH_EU2];
  assign wt  = out_reg[CH_WT];
  assign ovf = ovf_reg;

endmodule

// File: tb/tb_gwa_input_cond.sv
// Bench for gwa_input_cond: directed scenarios plus randomized inputs, all
// compared every cycle against a sample-window reference model.
module tb_gwa_input_cond;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst_n, eu1_raw, eu2_raw, wt_raw, hold;
  logic eu1, eu2, wt, ovf;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: per channel the last DEB+1 raw samples (index 0 =
  // most recent), the debounced level, the pending flag and expected outputs.
  bit hist   [3][DEB+1];
  bit m_deb  [3];
  bit m_pend [3];
  bit e_out  [3];
  bit e_ovf;

  gwa_input_cond #(
    .DEB_CYCLES(DEB),
    .CNT_W     (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .eu1_raw(eu1_raw),
    .eu2_raw(eu2_raw),
    .wt_raw (wt_raw),
    .hold   (hold),
    .eu1    (eu1),
    .eu2    (eu2),
    .wt     (wt),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Debounced level flips once the sample the synchroniser presents (one edge
  // old) and the DEB-1 samples before it all agree and differ from the level.
  task automatic model_step();
    bit r[3];
    bit rise[3];
    bit grant[3];
    r = '{eu1_raw, eu2_raw, wt_raw};
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) begin
        for (int i = 0; i <= DEB; i++) hist[c][i] = 1'b0;
        m_deb[c] = 1'b0; m_pend[c] = 1'b0; e_out[c] = 1'b0;
      end
      e_ovf = 1'b0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        bit all1, all0;
        all1 = 1'b1; all0 = 1'b1;
        for (int i = 1; i <= DEB; i++) begin
          if (hist[c][i]) all0 = 1'b0; else all1 = 1'b0;
        end
        rise[c] = 1'b0;
        if (all1 && !m_deb[c]) begin
          m_deb[c] = 1'b1; rise[c] = 1'b1;
        end else if (all0 && m_deb[c]) begin
          m_deb[c] = 1'b0;
        end
        for (int i = DEB; i >= 1; i--) hist[c][i] = hist[c][i-1];
        hist[c][0] = r[c];
        grant[c] = 1'b0;
      end
      if (!hold) begin
        for (int c = 0; c < 3; c++) begin
          if (m_pend[c]) begin grant[c] = 1'b1; break; end
        end
      end
      e_ovf = 1'b0;
      for (int c = 0; c < 3; c++) begin
        if (rise[c] && m_pend[c] && !grant[c]) e_ovf = 1'b1;
        m_pend[c] = (m_pend[c] && !grant[c]) || rise[c];
        e_out[c]  = grant[c];
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq("eu1", eu1, e_out[0]);
    check_eq("eu2", eu2, e_out[1]);
    check_eq("wt",  wt,  e_out[2]);
    check_eq("ovf", ovf, e_ovf);
    check_eq("onehot", (32'(eu1) + 32'(eu2) + 32'(wt)) <= 1, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; eu1_raw = 1'b0; eu2_raw = 1'b0; wt_raw = 1'b0; hold = 1'b0;
    cycle();
    check_eq("rst_outs", {eu1, eu2, wt, ovf}, 0);
    rst_n = 1'b1;
  endtask

  int first, npulse, nsec, nthird, novf;
  int seg_left[4];
  bit lvl[4];

  initial begin
    do_reset();

    // Clean insertion: pulse after exactly DEB+2 further edges, only once.
    eu1_raw = 1'b1; first = -1; npulse = 0;
    for (int i = 0; i < 14; i++) begin
      cycle();
      if (eu1) begin if (first < 0) first = i; npulse++; end
      if (eu2 || wt || ovf) npulse += 100;
    end
    eu1_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin cycle(); if (eu1) npulse++; end
    check_eq("clean_lat", first, DEB + 2);
    check_eq("clean_cnt", npulse, 1);

    // Bounce: 3-cycle highs are rejected, final stable high gives one pulse.
    do_reset();
    npulse = 0;
    for (int s = 0; s < 4; s++) begin
      wt_raw = (s % 2 == 0);
      for (int i = 0; i < 3; i++) begin cycle(); if (wt) npulse++; end
    end
    wt_raw = 1'b1; first = -1;
    for (int i = 0; i < 14; i++) begin
      cycle();
      if (wt) begin if (first < 0) first = i; npulse++; end
    end
    check_eq("bounce_lat", first, DEB + 2);
    check_eq("bounce_cnt", npulse, 1);

    // Simultaneous events drain in priority order on consecutive cycles.
    do_reset();
    eu1_raw = 1'b1; eu2_raw = 1'b1; wt_raw = 1'b1;
    first = -1; nsec = -1; nthird = -1;
    for (int i = 0; i < 14; i++) begin
      cycle();
      if (eu1 && first  < 0) first  = i;
      if (eu2 && nsec   < 0) nsec   = i;
      if (wt  && nthird < 0) nthird = i;
    end
    check_eq("sim_eu1", first,  DEB + 2);
    check_eq("sim_eu2", nsec,   DEB + 3);
    check_eq("sim_wt",  nthird, DEB + 4);

    // Hold and overflow: second debounced rise while pending is dropped.
    do_reset();
    hold = 1'b1; novf = 0; npulse = 0;
    for (int s = 0; s < 3; s++) begin
      eu2_raw = (s != 1);
      for (int i = 0; i < 10; i++) begin cycle(); if (ovf) novf++; if (eu2) npulse++; end
    end
    check_eq("hold_ovf", novf, 1);
    check_eq("hold_quiet", npulse, 0);
    hold = 1'b0;
    cycle();
    check_eq("hold_release", eu2, 1);
    for (int i = 0; i < 8; i++) begin cycle(); if (eu2) npulse++; end
    check_eq("hold_single", npulse, 0);

    // Reset discards a pending event.
    do_reset();
    hold = 1'b1; eu1_raw = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    eu1_raw = 1'b0;
    for (int i = 0; i < 8; i++) cycle();
    rst_n = 1'b0;
    cycle();
    check_eq("mid_rst_outs", {eu1, eu2, wt, ovf}, 0);
    rst_n = 1'b1; hold = 1'b0; npulse = 0;
    for (int i = 0; i < 12; i++) begin cycle(); if (eu1) npulse++; end
    check_eq("mid_rst_drop", npulse, 0);

    // Input held through reset is reported once after normal latency.
    hold = 1'b1; eu1_raw = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1; hold = 1'b0; first = -1; npulse = 0;
    for (int i = 0; i < 14; i++) begin
      cycle();
      if (eu1) begin if (first < 0) first = i; npulse++; end
    end
    check_eq("held_rst_lat", first, DEB + 2);
    check_eq("held_rst_cnt", npulse, 1);

    // Randomized segments of raw levels and hold, with occasional reset.
    eu1_raw = 1'b0; eu2_raw = 1'b0; wt_raw = 1'b0; hold = 1'b0;
    for (int c = 0; c < 4; c++) begin seg_left[c] = 1; lvl[c] = 1'b0; end
    for (int n = 0; n < 4000; n++) begin
      for (int c = 0; c < 4; c++) begin
        seg_left[c]--;
        if (seg_left[c] <= 0) begin
          if (c == 3) begin
            lvl[c] = ($urandom_range(0, 9) < 3);
            seg_left[c] = int'($urandom_range(1, 20));
          end else begin
            lvl[c] = ~lvl[c];
            seg_left[c] = int'($urandom_range(1, 9));
          end
        end
      end
      eu1_raw = lvl[0]; eu2_raw = lvl[1]; wt_raw = lvl[2]; hold = lvl[3];
      rst_n = ($urandom_range(0, 499) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
